// File: rtl/systa_template_gen.sv
// -----------------------------------------------------------------------------
// systa_template_gen
//   Emits the two-channel pulse train matched by the systA filter of the same
//   SUBTYPE. Each pulse is three beats, with two samples per channel per beat
//   (lane 0 earlier in time than lane 1). Each template coefficient is scaled
//   by the signed amplitude latched at start. Pulses repeat rep times, with
//   gap idle beats between them.
//
// Parameters
//   SUBTYPE  0 or 1, selects the template
//   INBITS   sample width (>= 4); amp is INBITS-2 wide, so |4*amp| always fits
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      start request, sampled only in IDLE
//   amp_i        signed amplitude (INBITS-2), latched with start
//   rep_i        pulse count, latched with start (0 behaves as 1)
//   gap_i        idle beats between pulses, latched with start
//   abort_i      (only with SYSTA_TGEN_ABORT_EN) return to IDLE immediately
//   outA0_o..outB1_o  registered signed samples
//   valid_o      beat carries template samples
//   busy_o       not IDLE
//   done_o       single-cycle completion pulse, coincident with busy_o falling
//
// Optional feature macro: SYSTA_TGEN_ABORT_EN (adds abort_i)
//
//   state | meaning
//   IDLE  | waiting for start_i
//   EMIT  | emitting beats 0..2 of one pulse
//   GAP   | idle beats between pulses, counted down from gap
// -----------------------------------------------------------------------------
module systa_template_gen #(
   parameter int SUBTYPE = 0,
   parameter int INBITS  = 12
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic signed [INBITS-3:0] amp_i,
   input  logic        [7:0]        rep_i,
   input  logic        [7:0]        gap_i,
`ifdef SYSTA_TGEN_ABORT_EN
   input  logic                     abort_i,
`endif
   output logic signed [INBITS-1:0] outA0_o,
   output logic signed [INBITS-1:0] outA1_o,
   output logic signed [INBITS-1:0] outB0_o,
   output logic signed [INBITS-1:0] outB1_o,
   output logic                     valid_o,
   output logic                     busy_o,
   output logic                     done_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EMIT = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t                     state_q,    state_d;
   logic        [1:0]          beat_q,     beat_d;
   logic        [7:0]          gap_cnt_q,  gap_cnt_d;
   logic        [7:0]          rep_left_q, rep_left_d;
   logic        [7:0]          gap_q,      gap_d;
   logic signed [INBITS-3:0]   amp_q,      amp_d;
   logic signed [INBITS-1:0]   out_q [4];
   logic signed [INBITS-1:0]   out_d [4];
   logic                       valid_q,    valid_d;
   logic                       busy_q,     busy_d;
   logic                       done_q,     done_d;
   logic                       abort_w;
   logic signed [INBITS-1:0]   amp_ext;

`ifdef SYSTA_TGEN_ABORT_EN
   assign abort_w = abort_i;
`else
   assign abort_w = 1'b0;
`endif

   // Template coefficient for (beat, lane); lanes are A0, A1, B0, B1.
   function automatic logic signed [3:0] tpl_coef(input logic [1:0] beat,
                                                  input logic [1:0] lane);
      logic signed [3:0] c;
      c = 4'sd0;
      if (SUBTYPE == 1) begin
         case ({beat, lane})
            4'b00_00: c =  4'sd1;
            4'b00_10: c =  4'sd1;
            4'b00_11: c = -4'sd2;
            4'b01_01: c =  4'sd1;
            4'b01_10: c = -4'sd1;
            4'b01_11: c = -4'sd1;
            4'b10_00: c =  4'sd1;
            default:  c =  4'sd0;
         endcase
      end else begin
         case ({beat, lane})
            4'b00_00: c = -4'sd1;
            4'b00_01: c =  4'sd4;
            4'b00_10: c =  4'sd4;
            4'b00_11: c = -4'sd2;
            4'b01_00: c =  4'sd2;
            4'b01_01: c =  4'sd1;
            4'b01_10: c = -4'sd1;
            default:  c =  4'sd0;
         endcase
      end
      return c;
   endfunction

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      gap_cnt_d  = gap_cnt_q;
      rep_left_d = rep_left_q;
      gap_d      = gap_q;
      amp_d      = amp_q;
      done_d     = 1'b0;

      if (abort_w) begin
         // Abort wins over everything, including a simultaneous start.
         state_d   = ST_IDLE;
         beat_d    = 2'd0;
         gap_cnt_d = 8'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  state_d    = ST_EMIT;
                  beat_d     = 2'd0;
                  amp_d      = amp_i;
                  gap_d      = gap_i;
                  rep_left_d = (rep_i == 8'd0) ? 8'd1 : rep_i;
               end
            end
            ST_EMIT: begin
               if (beat_q == 2'd2) begin
                  beat_d = 2'd0;
                  if (rep_left_q == 8'd1) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     rep_left_d = rep_left_q - 8'd1;
                     if (gap_q != 8'd0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap_q;
                     end
                  end
               end else begin
                  beat_d = beat_q + 2'd1;
               end
            end
            ST_GAP: begin
               if (gap_cnt_q == 8'd1) begin
                  state_d   = ST_EMIT;
                  beat_d    = 2'd0;
                  gap_cnt_d = 8'd0;
               end else begin
                  gap_cnt_d = gap_cnt_q - 8'd1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               beat_d  = 2'd0;
            end
         endcase
      end

      // Outputs are computed from the next state so they register one cycle
      // after the edge that selects them.
      valid_d = (state_d == ST_EMIT);
      busy_d  = (state_d != ST_IDLE);
      amp_ext = INBITS'(amp_d);
      for (int l = 0; l < 4; l++) begin
         out_d[l] = valid_d ? amp_ext * INBITS'(tpl_coef(beat_d, 2'(l))) : '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         beat_q     <= 2'd0;
         gap_cnt_q  <= 8'd0;
         rep_left_q <= 8'd0;
         gap_q      <= 8'd0;
         amp_q      <= '0;
         out_q      <= '{default: '0};
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         gap_cnt_q  <= gap_cnt_d;
         rep_left_q <= rep_left_d;
         gap_q      <= gap_d;
         amp_q      <= amp_d;
         out_q      <= out_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign outA0_o = out_q[0];
   assign outA1_o = out_q[1];
   assign outB0_o = out_q[2];
   assign outB1_o = out_q[3];
   assign valid_o = valid_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;

endmodule

// File: doc/systa_template_gen.md
SYSTA_TEMPLATE_GEN -- requirements
Module: systa_template_gen

Interface
REQ-001 Parameter SUBTYPE, default 0: selects the systA template (0 or 1); any other value is illegal.
REQ-002 Parameter INBITS, default 12: signed sample width per lane; must be at least 4.
REQ-003 clk_i  input  1  sole clock; all logic on its rising edge.
REQ-004 rst_ni  input  1  reset; asynchronous, active-low.
REQ-005 start_i  input  1  request to emit a pulse train; sampled only in IDLE.
REQ-006 amp_i  input  INBITS-2  signed amplitude; captured with start_i.
REQ-007 rep_i  input  8  number of pulses; captured with start_i; 0 is treated as 1.
REQ-008 gap_i  input  8  idle beats between pulses; captured with start_i.
REQ-009 outA0_o, outA1_o, outB0_o, outB1_o  output  INBITS each  signed samples; lane 0 is earlier in time than lane 1.
REQ-010 valid_o  output  1  high on beats that carry template samples.
REQ-011 busy_o  output  1  high in any state other than IDLE.
REQ-012 done_o  output  1  one-cycle pulse on completion.

Function
REQ-013 The block emits the two-channel pulse matched by the systA filter of the same SUBTYPE, at two samples per channel per clock.
REQ-014 SUBTYPE 0 beats (A0,A1,B0,B1) are multiplied by amp: beat0 (-1,4,4,-2); beat1 (2,1,-1,0); beat2 (0,0,0,0).
REQ-015 SUBTYPE 1 beats (A0,A1,B0,B1) are multiplied by amp: beat0 (1,0,1,-2); beat1 (0,1,-1,-1); beat2 (1,0,0,0).
REQ-016 Products are exact with no saturation, because the INBITS-2 width of amp guarantees that |4*amp| fits in INBITS signed.
REQ-017 The state machine has three states: IDLE, EMIT (beat counter 0..2) and GAP (gap counter).
REQ-018 IDLE to EMIT occurs on the edge where start_i=1; amp, rep and gap are latched on that same edge.
REQ-019 EMIT lasts exactly 3 beats, with valid_o=1 on each.
REQ-020 After beat2, the FSM goes to IDLE if the remaining pulse count is 1, otherwise to GAP if gap>0, otherwise straight back to EMIT beat0.
REQ-021 GAP holds for gap beats with outputs zero and valid_o=0, then returns to EMIT beat0.
REQ-022 All outputs are registered; the first beat appears in the cycle following the start_i edge (latency 1).
REQ-023 Outside EMIT, all sample outputs are 0 and valid_o is 0.
REQ-024 done_o is high for exactly the single cycle after the last beat of the last pulse, coincident with busy_o falling.
REQ-025 start_i asserted while busy_o=1 is ignored and is not queued.
REQ-026 start_i asserted in the cycle done_o is high is accepted, so back-to-back trains have a one-cycle idle bubble.
REQ-027 Changes to amp_i, rep_i or gap_i during a train have no effect.

Reset
REQ-028 While rst_ni=0, the state is IDLE, all counters and latched values are 0, all sample outputs are 0, and valid_o, busy_o and done_o are 0.
REQ-029 Reset asserted mid-train aborts immediately, without a done_o pulse.
REQ-030 After rst_ni deasserts, the block waits for a new start_i.

Configuration
REQ-031 With macro SYSTA_TGEN_ABORT_EN defined, the block has an extra input abort_i (1 bit).
REQ-032 When abort_i=1 on a clock edge while busy, the FSM returns to IDLE on that edge, outputs are 0 from the next cycle, and no done_o pulse is produced.
REQ-033 When abort_i and start_i are both high in IDLE, abort wins and start is ignored.
REQ-034 Without SYSTA_TGEN_ABORT_EN, the abort_i port and its logic are absent, and trains terminate only by completion or reset.

Verification
REQ-035 SUBTYPE 0, INBITS 12, amp=100, rep=1, gap=0, start pulse -> next 3 cycles (A0,A1,B0,B1) = (-100,400,400,-200), (200,100,-100,0), (0,0,0,0) with valid=1; then done_o for 1 cycle.
REQ-036 SUBTYPE 1, amp=-512, rep=2, gap=2 -> beats (-512,0,-512,1024), (0,-512,512,512), (-512,0,0,0); then 2 zero beats with valid=0; then the same 3 beats again; then done_o.
REQ-037 SUBTYPE 0, amp=511 and amp=-512 -> peak outputs 2044 and -2048 exactly, with no wrap.
REQ-038 start_i re-pulsed at beat1 of a train -> ignored; start_i held high through done_o -> second train begins the cycle after done_o.
REQ-039 rst_ni pulled low at beat1 -> outputs, valid_o and busy_o go to 0 asynchronously, and no done_o pulse occurs.
REQ-040 With SYSTA_TGEN_ABORT_EN and rep=3, abort_i asserted at GAP -> IDLE, busy_o=0 from the next cycle, and done_o stays 0.
